// File: rtl/alu_multicycle_if.sv
// Start/done handshake and operand/result bundle between the controller and the
// multi-cycle ALU.
interface alu_multicycle_if #(
    parameter int unsigned DW = 32
);
    logic          start;
    logic [3:0]    op;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic          ready;
    logic          busy;
    logic          done;
    logic [DW:0]   result;
    logic [4:0]    psr;
    logic          op_err;

    modport master (
        output start, op, src1, src2,
        input  ready, busy, done, result, psr, op_err
    );

    modport slave (
        input  start, op, src1, src2,
        output ready, busy, done, result, psr, op_err
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: ADD/CMP finish in one cycle, MUL/SHF/ROT iterate one bit per cycle.
// Result and PSR flags are registered together in the cycle the operation completes.
module alu_multicycle #(
    parameter int unsigned DW  = 32,
    parameter int unsigned SHW = 5
) (
    input logic            clk,
    input logic            reset,
    alu_multicycle_if.slave bus
);
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpMul = 4'b0101;
    localparam logic [3:0] OpCmp = 4'b0110;
    localparam logic [3:0] OpShf = 4'b0111;
    localparam logic [3:0] OpRot = 4'b1000;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [DW:0]     mcand_q, mcand_d;
    logic [DW:0]     acc_q, acc_d;
    logic [DW-1:0]   b_q, b_d;
    logic            right_q, right_d;
    logic            cout_q, cout_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [DW:0]     result_q, result_d;
    logic [4:0]      psr_q, psr_d;
    logic            op_err_q, op_err_d;

    logic            load_res;
    logic [DW:0]     res_new;
    logic            e_new;
    logic            n_new, z_new;
    logic [SHW-1:0]  amt;

    assign amt = bus.src1[SHW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            right_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            psr_q    <= '0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            right_q  <= right_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            psr_q    <= psr_d;
            op_err_q <= op_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        b_d      = b_q;
        right_d  = right_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        op_err_d = 1'b0;
        load_res = 1'b0;
        res_new  = '0;
        e_new    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    b_d     = bus.src2;
                    mcand_d = {1'b0, bus.src1};
                    acc_d   = '0;
                    right_d = bus.src1[SHW];
                    cout_d  = 1'b0;
                    state_d = StDone;
                    case (bus.op)
                        OpAdd: begin
                            res_new  = {1'b0, bus.src1} + {1'b0, bus.src2};
                            load_res = 1'b1;
                        end
                        OpCmp: begin
                            res_new  = {1'b0, bus.src1} - {1'b0, bus.src2};
                            e_new    = (bus.src1 == bus.src2);
                            load_res = 1'b1;
                        end
                        OpMul: begin
                            cnt_d   = SHW'(DW - 1);
                            state_d = StRun;
                        end
                        OpShf, OpRot: begin
                            if (amt == '0) begin
                                res_new  = {1'b0, bus.src2};
                                load_res = 1'b1;
                            end else begin
                                cnt_d   = amt - 1'b1;
                                state_d = StRun;
                            end
                        end
                        default: op_err_d = 1'b1;
                    endcase
                end
            end
            StRun: begin
                case (op_q)
                    OpMul: begin
                        acc_d   = acc_q + (b_q[0] ? mcand_q : '0);
                        mcand_d = mcand_q << 1;
                        b_d     = b_q >> 1;
                    end
                    OpShf: begin
                        if (right_q) begin
                            cout_d = b_q[0];
                            b_d    = b_q >> 1;
                        end else begin
                            cout_d = b_q[DW-1];
                            b_d    = b_q << 1;
                        end
                    end
                    OpRot:   b_d = {b_q[DW-2:0], b_q[DW-1]};
                    default: ;
                endcase
                // The final step's values are what get registered as the result.
                if (cnt_q == '0) begin
                    state_d  = StDone;
                    load_res = 1'b1;
                    res_new  = (op_q == OpMul) ? acc_d : {cout_d, b_d};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign n_new = res_new[DW-1];
    assign z_new = (res_new[DW-1:0] == '0);

    always_comb begin
        result_d = result_q;
        psr_d    = psr_q;
        if (load_res) begin
            result_d = res_new;
            psr_d    = {n_new, z_new, !n_new && !z_new, e_new, res_new[DW]};
        end
    end

    assign bus.ready  = (state_q == StIdle);
    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.psr    = psr_q;
    assign bus.op_err = op_err_q;
endmodule
